// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-ordered activation stream.
// A half-width line buffer carries horizontal pair maxima from even rows to odd rows.
module maxpool_2x2 #(
  parameter int dataWidth = 8,
  parameter int IMG_W     = 26,
  parameter int IMG_H     = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [dataWidth-1:0] in_data,
  output logic                 out_valid,
  output logic [dataWidth-1:0] out_data,
  output logic                 frame_done
);

  localparam int PW = IMG_W / 2;
  localparam int PH = IMG_H / 2;
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] LAST_POOL_ROW = RW'(2 * PH - 1);

  typedef enum logic [1:0] {IDLE_ROW, POOL_ROW, DISCARD} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic [dataWidth-1:0] r_h;
  logic                 r_out_valid;
  logic [dataWidth-1:0] r_out_data;
  logic                 r_frame_done;
  logic [dataWidth-1:0] r_line_buf [PW];

  logic [LW-1:0]        w_lb_idx;
  logic [dataWidth-1:0] w_lb_rd;
  logic [dataWidth-1:0] w_hmax;
  logic [dataWidth-1:0] w_vmax;

  function automatic logic [dataWidth-1:0] smax(input logic [dataWidth-1:0] a,
                                                input logic [dataWidth-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  always_comb begin
    w_lb_idx = LW'(r_col >> 1);
    w_lb_rd  = r_line_buf[w_lb_idx];
    w_hmax   = smax(r_h, in_data);
    w_vmax   = smax(w_lb_rd, w_hmax);
  end

  // Line buffer is deliberately not reset: each entry is rewritten on every even row before use.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && r_col[0] && r_state == IDLE_ROW)
      r_line_buf[w_lb_idx] <= w_hmax;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE_ROW;
      r_col        <= '0;
      r_row        <= '0;
      r_h          <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (in_valid) begin
        if (!r_col[0]) begin
          r_h <= in_data;
        end else if (r_state == POOL_ROW) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_vmax;
        end

        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_row == ROW_LAST) begin
            r_row        <= '0;
            r_state      <= IDLE_ROW;
            r_frame_done <= 1'b1;
          end else begin
            r_row <= r_row + RW'(1);
            // Leaving the last complete row pair of an odd-height frame enters the discard pass.
            if (r_row == LAST_POOL_ROW)
              r_state <= DISCARD;
            else
              r_state <= (r_state == IDLE_ROW) ? POOL_ROW : IDLE_ROW;
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

endmodule
